// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between the echo (0) and status (1) byte sources.
// Define UART_TX_ARB_RR_EN for round-robin tie-breaking; the default build gives source 0 fixed priority.
module uart_tx_arbiter #(
    parameter int FRAME_CYCLES = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       grant_id,
    output logic       busy
);

`ifdef UART_TX_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    localparam logic [7:0] CNT_LOAD = 8'(FRAME_CYCLES - 1);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       last, last_nxt;
    logic       ack0_nxt, ack1_nxt, tx_start_nxt, busy_nxt, grant_id_nxt;
    logic [7:0] tx_data_nxt;
    logic       winner;

    // Winner id; only meaningful when at least one request is high.
    function automatic logic pick_winner(input logic r0, input logic r1, input logic lst);
        if (r0 && r1) return RR_EN ? ~lst : 1'b0;
        return r1;
    endfunction

    assign winner = pick_winner(req0, req1, last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            last     <= 1'b1;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            tx_start <= 1'b0;
            busy     <= 1'b0;
            grant_id <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            last     <= last_nxt;
            ack0     <= ack0_nxt;
            ack1     <= ack1_nxt;
            tx_start <= tx_start_nxt;
            busy     <= busy_nxt;
            grant_id <= grant_id_nxt;
            tx_data  <= tx_data_nxt;
        end
    end

    // cnt holds the frame cycles still to come after the current one, so SEND ends when it is 0.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0 || req1) state_nxt = SEND;
            SEND:    if (cnt == 8'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt      = cnt;
        last_nxt     = last;
        ack0_nxt     = 1'b0;
        ack1_nxt     = 1'b0;
        tx_start_nxt = 1'b0;
        busy_nxt     = busy;
        grant_id_nxt = grant_id;
        tx_data_nxt  = tx_data;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    tx_data_nxt  = winner ? data1 : data0;
                    grant_id_nxt = winner;
                    ack0_nxt     = ~winner;
                    ack1_nxt     = winner;
                    tx_start_nxt = 1'b1;
                    busy_nxt     = 1'b1;
                    cnt_nxt      = CNT_LOAD;
                    last_nxt     = winner;
                end
            end
            SEND: begin
                if (cnt == 8'd0) begin
                    busy_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: default-frame instance plus a FRAME_CYCLES=2 instance.
module tb_uart_tx_arbiter;

`ifdef UART_TX_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       id;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, ack0, ack1, tx_start, grant_id, busy;
    logic [7:0] data0, data1, tx_data;
    logic       req0_s, req1_s, ack0_s, ack1_s, tx_start_s, grant_id_s, busy_s;
    logic [7:0] data0_s, data1_s, tx_data_s;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sb[$];

    uart_tx_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .tx_data(tx_data), .tx_start(tx_start), .grant_id(grant_id), .busy(busy)
    );

    uart_tx_arbiter #(.FRAME_CYCLES(2)) dut_short (
        .clk(clk), .rst(rst),
        .req0(req0_s), .data0(data0_s), .ack0(ack0_s),
        .req1(req1_s), .data1(data1_s), .ack1(ack1_s),
        .tx_data(tx_data_s), .tx_start(tx_start_s), .grant_id(grant_id_s), .busy(busy_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
        req0_s = 1'b0; req1_s = 1'b0; data0_s = 8'h00; data1_s = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
        req0_s = 1'b0; req1_s = 1'b0; data0_s = 8'h00; data1_s = 8'h00;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ack0, ack1, tx_start, busy, grant_id, tx_data} !== 13'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {ack0, ack1, tx_start, busy, grant_id, tx_data});
        end
        checks++;
        if ({ack0_s, ack1_s, tx_start_s, busy_s, grant_id_s, tx_data_s} !== 13'h0) begin
            failures++;
            $display("FAIL reset_outputs_short got=%h exp=0", {ack0_s, ack1_s, tx_start_s, busy_s, grant_id_s, tx_data_s});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ack0, ack1, tx_start, busy, grant_id, tx_data} !== 13'h0) begin
            failures++;
            $display("FAIL idle_hold got=%h exp=0", {ack0, ack1, tx_start, busy, grant_id, tx_data});
        end
    endtask

    task automatic test_single();
        exp_t e;
        int   busy_cnt;
        int   extra;
        apply_reset();
        data0 = 8'hA5;
        req0  = 1'b1;
        sb.push_back('{data: 8'hA5, id: 1'b0});
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b0) begin
            failures++;
            $display("FAIL single_early got=%b exp=0", tx_start);
        end
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1) begin
            failures++;
            $display("FAIL single_latency got=%b exp=1", tx_start);
        end
        e = sb.pop_front();
        checks++;
        if (tx_data !== e.data || grant_id !== e.id || {ack0, ack1} !== 2'b10) begin
            failures++;
            $display("FAIL single_grant got=%h/%b/%b%b exp=%h/%b/10", tx_data, grant_id, ack0, ack1, e.data, e.id);
        end
        req0 = 1'b0;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        extra = 0;
        repeat (14) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (tx_start !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) extra++;
        end
        checks++;
        if (busy_cnt != 11) begin
            failures++;
            $display("FAIL single_busy_len got=%0d exp=11", busy_cnt);
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL single_pulse_width got=%0d exp=0", extra);
        end
        checks++;
        if (tx_data !== 8'hA5 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_hold got=%h/%b exp=a5/0", tx_data, busy);
        end
    endtask

    task automatic test_tie();
        exp_t e;
        int   waited;
        int   last_cyc;
        bit   ack1_seen;
        apply_reset();
        data0 = 8'h11;
        data1 = 8'h22;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int g = 0; g < 4; g++) begin
            if (RR && (g % 2 == 1)) sb.push_back('{data: 8'h22, id: 1'b1});
            else                    sb.push_back('{data: 8'h11, id: 1'b0});
        end
        last_cyc = 0;
        ack1_seen = 1'b0;
        for (int g = 0; g < 4; g++) begin
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
                if (ack1 === 1'b1) ack1_seen = 1'b1;
            end while (tx_start !== 1'b1 && waited < 40);
            checks++;
            if (tx_start !== 1'b1) begin
                failures++;
                $display("FAIL tie_timeout got=no_start exp=start grant=%0d", g);
            end else begin
                e = sb.pop_front();
                checks++;
                if (tx_data !== e.data || grant_id !== e.id || {ack0, ack1} !== (e.id ? 2'b01 : 2'b10)) begin
                    failures++;
                    $display("FAIL tie_grant%0d got=%h/%b/%b%b exp=%h/%b", g, tx_data, grant_id, ack0, ack1, e.data, e.id);
                end
                if (g > 0) begin
                    checks++;
                    if (cyc - last_cyc != 12) begin
                        failures++;
                        $display("FAIL tie_period got=%0d exp=12", cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        checks++;
        if (ack1_seen !== RR) begin
            failures++;
            $display("FAIL tie_ack1_seen got=%b exp=%b", ack1_seen, RR);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_late_req();
        exp_t e;
        int   waited;
        int   start_c;
        logic pb;
        bit   early;
        apply_reset();
        data0 = 8'h3C;
        req0  = 1'b1;
        sb.push_back('{data: 8'h3C, id: 1'b0});
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (tx_start !== 1'b1 && waited < 10);
        e = sb.pop_front();
        checks++;
        if (tx_start !== 1'b1 || tx_data !== e.data || grant_id !== e.id) begin
            failures++;
            $display("FAIL late_first got=%b/%h/%b exp=1/%h/%b", tx_start, tx_data, grant_id, e.data, e.id);
        end
        start_c = cyc;
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        data1 = 8'h5A;
        req1  = 1'b1;
        sb.push_back('{data: 8'h5A, id: 1'b1});
        waited = 0;
        early = 1'b0;
        pb = 1'b1;
        do begin
            pb = busy;
            @(negedge clk);
            waited++;
            if (ack1 === 1'b1 && tx_start !== 1'b1) early = 1'b1;
        end while (tx_start !== 1'b1 && waited < 30);
        checks++;
        if (cyc - start_c != 12) begin
            failures++;
            $display("FAIL late_start_cycle got=%0d exp=12", cyc - start_c);
        end
        checks++;
        if (early || pb !== 1'b0) begin
            failures++;
            $display("FAIL late_idle_gap got=early%b/prevbusy%b exp=early0/prevbusy0", early, pb);
        end
        e = sb.pop_front();
        checks++;
        if (tx_data !== e.data || grant_id !== e.id || {ack0, ack1} !== 2'b01) begin
            failures++;
            $display("FAIL late_grant got=%h/%b/%b%b exp=%h/%b/01", tx_data, grant_id, ack0, ack1, e.data, e.id);
        end
        req1 = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   waited;
        apply_reset();
        data0 = 8'h77;
        req0  = 1'b1;
        sb.push_back('{data: 8'h77, id: 1'b0});
        sb.push_back('{data: 8'h77, id: 1'b0});
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (tx_start !== 1'b1 && waited < 10);
        e = sb.pop_front();
        checks++;
        if (tx_start !== 1'b1 || tx_data !== e.data) begin
            failures++;
            $display("FAIL rmid_first got=%b/%h exp=1/%h", tx_start, tx_data, e.data);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ack0, ack1, tx_start, busy, grant_id, tx_data} !== 13'h0) begin
            failures++;
            $display("FAIL rmid_outputs got=%h exp=0", {ack0, ack1, tx_start, busy, grant_id, tx_data});
        end
        rst = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (tx_start !== 1'b1 || tx_data !== e.data || {ack0, ack1} !== 2'b10 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rmid_regrant got=%b/%h/%b%b/%b exp=1/%h/10/1", tx_start, tx_data, ack0, ack1, busy, e.data);
        end
        req0 = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_short_frame();
        int waited;
        int starts;
        int busy_c;
        int bad_phase;
        data0_s = 8'h96;
        req0_s  = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (tx_start_s !== 1'b1 && waited < 10);
        checks++;
        if (tx_start_s !== 1'b1) begin
            failures++;
            $display("FAIL short_first got=%b exp=1", tx_start_s);
        end
        starts = 0;
        busy_c = 0;
        bad_phase = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (tx_start_s === 1'b1) begin
                starts++;
                if (i % 3 != 2) bad_phase++;
            end
            if (busy_s === 1'b1) busy_c++;
        end
        checks++;
        if (starts != 3 || bad_phase != 0) begin
            failures++;
            $display("FAIL short_period got=%0d/%0d exp=3/0", starts, bad_phase);
        end
        checks++;
        if (busy_c != 6) begin
            failures++;
            $display("FAIL short_busy got=%0d exp=6", busy_c);
        end
        checks++;
        if (tx_data_s !== 8'h96 || grant_id_s !== 1'b0) begin
            failures++;
            $display("FAIL short_data got=%h/%b exp=96/0", tx_data_s, grant_id_s);
        end
        req0_s = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_late_req();
        test_reset_mid();
        test_short_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
